// File: rtl/apbdma_pkg.sv
// Shared types and width helpers for the APB DMA transfer engine.
package apbdma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      SETUP,
      ACCESS,
      DONE
   } apbdma_mst_state_e;

   // Bytes carried by one APB beat.
   function automatic int unsigned apbdma_bpb(input int unsigned data_width);
      return data_width / 8;
   endfunction

   // Number of byte-offset address bits inside one beat.
   function automatic int unsigned apbdma_off_bits(input int unsigned data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/apbdma_apb_master_if.sv
// APB bus between the DMA transfer engine (master) and an APB completer (slave).
interface apbdma_apb_master_if
   import apbdma_pkg::*;
#(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
) ();

   logic [AddrWidth-1:0]                  paddr;
   logic                                  psel;
   logic                                  penable;
   logic                                  pwrite;
   logic [DataWidth-1:0]                  pwdata;
   logic [apbdma_bpb(DataWidth)-1:0]      pstrb;
   logic [DataWidth-1:0]                  prdata;
   logic                                  pready;
   logic                                  pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apbdma_apb_master.sv
// APB transfer engine of the DMA: walks a word-aligned descriptor one APB beat at a
// time, feeding the read FIFO or draining the write stream, and reports busy/done/err.
module apbdma_apb_master
   import apbdma_pkg::*;
#(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32,
   parameter int LenWidth  = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 rw_i,
   input  logic [AddrWidth-1:0] start_addr_i,
   input  logic [LenWidth-1:0]  num_bytes_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   apbdma_apb_master_if.master  apb,
   output logic [DataWidth-1:0] rdata_o,
   output logic                 rdata_valid_o,
   input  logic                 rdata_ready_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic                 wdata_valid_i,
   output logic                 wdata_ready_o
);

   localparam int unsigned          Bpb       = apbdma_bpb(DataWidth);
   localparam int unsigned          OffBits   = apbdma_off_bits(DataWidth);
   localparam logic [AddrWidth-1:0] BpbInc    = AddrWidth'(Bpb);
   localparam logic [AddrWidth-1:0] AlignMask = ~(BpbInc - AddrWidth'(1));

   apbdma_mst_state_e    state_q, state_d;
   logic                 start_q;
   logic [AddrWidth-1:0] addr_q;
   logic [LenWidth-1:0]  beats_q;
   logic                 rw_q;
   logic [DataWidth-1:0] pwdata_q;
   logic                 err_q;

   logic trigger;
   logic load;
   logic wlatch;
   logic beat_ok;
   logic beat_err;

   // Only a rising start edge seen while idle opens a transfer.
   assign trigger = start_i & ~start_q;

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      wlatch   = 1'b0;
      beat_ok  = 1'b0;
      beat_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (trigger) begin
               state_d = WAIT;
               load    = 1'b1;
            end
         end
         WAIT: begin
            if (beats_q == '0) begin
               state_d = DONE;
            end else if (rw_q ? wdata_valid_i : rdata_ready_i) begin
               state_d = SETUP;
               wlatch  = 1'b1;
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (apb.pready) begin
               if (apb.pslverr) begin
                  beat_err = 1'b1;
                  state_d  = DONE;
               end else begin
                  beat_ok = 1'b1;
                  state_d = WAIT;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         start_q  <= 1'b0;
         addr_q   <= '0;
         beats_q  <= '0;
         rw_q     <= 1'b0;
         pwdata_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_i;
         if (load) begin
            addr_q  <= start_addr_i & AlignMask;
            beats_q <= num_bytes_i >> OffBits;
            rw_q    <= rw_i;
            err_q   <= 1'b0;
         end
         if (wlatch) begin
            pwdata_q <= wdata_i;
         end
         // Address wraps silently at the top of the address space.
         if (beat_ok) begin
            addr_q  <= addr_q + BpbInc;
            beats_q <= beats_q - LenWidth'(1);
         end
         if (beat_err) begin
            err_q <= 1'b1;
         end
      end
   end

   assign busy_o        = (state_q != IDLE);
   assign done_o        = (state_q == DONE);
   assign err_o         = err_q;

   assign apb.psel      = (state_q == SETUP) || (state_q == ACCESS);
   assign apb.penable   = (state_q == ACCESS);
   assign apb.paddr     = addr_q;
   assign apb.pwrite    = rw_q;
   assign apb.pwdata    = pwdata_q;
   assign apb.pstrb     = apb.psel ? '1 : '0;

   assign rdata_valid_o = beat_ok & ~rw_q;
   assign rdata_o       = rdata_valid_o ? apb.prdata : '0;
   assign wdata_ready_o = beat_ok & rw_q;

endmodule

// File: tb/tb_apbdma_apb_master.sv
// Bench for apbdma_apb_master: directed vector table, corner-case sequences and
// randomized descriptors checked against a descriptor-level reference model.
module tb_apbdma_apb_master;
   import apbdma_pkg::*;

   localparam int          AW    = 32;
   localparam int          DW    = 32;
   localparam int          LW    = 8;
   localparam logic [31:0] SALT  = 32'h5A5A_0000;
   localparam logic [31:0] WBASE = 32'hC000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        rw;
   logic [31:0] start_addr;
   logic [7:0]  nbytes;
   logic        busy, done, err;
   logic [31:0] rdata;
   logic        rvalid, rready;
   logic [31:0] wdata;
   logic        wvalid, wready;

   apbdma_apb_master_if #(.AddrWidth(AW), .DataWidth(DW)) apb ();

   apbdma_apb_master #(.AddrWidth(AW), .DataWidth(DW), .LenWidth(LW)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .rw_i          (rw),
      .start_addr_i  (start_addr),
      .num_bytes_i   (nbytes),
      .busy_o        (busy),
      .done_o        (done),
      .err_o         (err),
      .apb           (apb),
      .rdata_o       (rdata),
      .rdata_valid_o (rvalid),
      .rdata_ready_i (rready),
      .wdata_i       (wdata),
      .wdata_valid_i (wvalid),
      .wdata_ready_o (wready)
   );

   always #5 clk = ~clk;

   // Completer model: data derived from address, optional error address and stall address.
   int          rdy_mode;
   logic        rdy_rand;
   logic        err_en, stall_en;
   logic [31:0] err_addr, stall_addr;
   int          stall_cnt;
   logic        in_acc;
   int          widx;
   bit          rand_wv;

   assign in_acc      = apb.psel && apb.penable;
   assign apb.prdata  = apb.paddr ^ SALT;
   assign apb.pready  = rdy_rand && !(stall_en && in_acc && apb.paddr == stall_addr && stall_cnt < 3);
   assign apb.pslverr = err_en && in_acc && apb.paddr == err_addr;
   assign wdata       = WBASE + 32'(widx);

   always @(posedge clk) begin
      if (!stall_en) stall_cnt <= 0;
      else if (in_acc && apb.paddr == stall_addr && stall_cnt < 3) stall_cnt <= stall_cnt + 1;
   end

   // Monitor: event counters and logs of completed beats.
   int          n_busy = 0, n_done = 0, n_setup = 0, n_proto = 0, n_stall_acc = 0;
   logic [31:0] q_acc[$], q_push[$], q_pop[$];
   logic [31:0] setup_addr = '0;
   logic        last_pop = 1'b0, prev_wv = 1'b0, prev_rr = 1'b0;

   always @(negedge clk) begin
      if (busy) n_busy++;
      if (done) n_done++;
      if (apb.psel && apb.pstrb != 4'hF) n_proto++;
      if (apb.psel && !apb.penable) begin
         n_setup++;
         setup_addr = apb.paddr;
         if (apb.pwrite ? !prev_wv : !prev_rr) n_proto++;
      end
      if (in_acc) begin
         if (apb.paddr != setup_addr) n_proto++;
         if (stall_en && apb.paddr == stall_addr) n_stall_acc++;
         if (apb.pready) q_acc.push_back(apb.paddr);
      end
      if (rvalid) begin
         if (!(in_acc && apb.pready)) n_proto++;
         q_push.push_back(rdata);
      end
      if (wready) begin
         if (!(in_acc && apb.pready)) n_proto++;
         q_pop.push_back(apb.pwdata);
      end
      last_pop = wready;
      prev_wv  = wvalid;
      prev_rr  = rready;
   end

   int n_chk = 0, n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock; stream and ready stimulus change 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (last_pop) begin
         widx++;
         wvalid = rand_wv ? 1'($urandom_range(1)) : 1'b1;
      end else if (!wvalid) begin
         wvalid = rand_wv ? 1'($urandom_range(1)) : 1'b1;
      end
      if (rand_wv) rready = ($urandom_range(3) != 0);
      case (rdy_mode)
         1:       rdy_rand = ($urandom_range(3) != 0);
         2:       rdy_rand = 1'b0;
         default: rdy_rand = 1'b1;
      endcase
   endtask

   task automatic run_xfer(input logic rw_v, input logic [31:0] addr_v, input logic [7:0] nb_v,
                           input logic een, input logic [31:0] eaddr,
                           output int acc_o, output int xfer_o, output int busy_cnt,
                           output logic [31:0] first_o);
      int          d_done, d_busy, d_proto, b_acc, b_push, b_pop, w0, cyc;
      logic [31:0] exp_a[$];
      logic [31:0] exp_d[$];
      logic        exp_err;
      logic [31:0] a;
      d_done = n_done; d_busy = n_busy; d_proto = n_proto;
      b_acc = q_acc.size(); b_push = q_push.size(); b_pop = q_pop.size();
      w0 = widx; exp_err = 1'b0; cyc = 0;
      // Reference: word addresses from the aligned start, stopping at the first error beat.
      for (int k = 0; k < int'(nb_v / 8'd4); k++) begin
         a = (addr_v & ~32'h3) + 32'(4 * k);
         exp_a.push_back(a);
         if (een && a == eaddr) begin
            exp_err = 1'b1;
            break;
         end
         exp_d.push_back(rw_v ? WBASE + 32'(w0 + exp_d.size()) : a ^ SALT);
      end
      err_en = een; err_addr = eaddr;
      rw = rw_v; start_addr = addr_v; nbytes = nb_v; start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_after_trigger", 64'(busy), 64'd1);
      chk("err_cleared_on_trigger", 64'(err), 64'd0);
      while (n_done == d_done && cyc < 3000) begin
         step();
         cyc++;
      end
      step();
      step();
      chk("done_pulses", 64'(n_done - d_done), 64'd1);
      chk("busy_end", 64'(busy), 64'd0);
      chk("err_o", 64'(err), 64'(exp_err));
      chk("protocol", 64'(n_proto - d_proto), 64'd0);
      acc_o = q_acc.size() - b_acc;
      chk("access_count", 64'(acc_o), 64'(exp_a.size()));
      for (int k = 0; k < exp_a.size() && b_acc + k < q_acc.size(); k++)
         chk("access_addr", 64'(q_acc[b_acc + k]), 64'(exp_a[k]));
      if (rw_v) begin
         xfer_o = q_pop.size() - b_pop;
         chk("pop_count", 64'(xfer_o), 64'(exp_d.size()));
         chk("no_push_on_write", 64'(q_push.size() - b_push), 64'd0);
         for (int k = 0; k < exp_d.size() && b_pop + k < q_pop.size(); k++)
            chk("pwdata", 64'(q_pop[b_pop + k]), 64'(exp_d[k]));
      end else begin
         xfer_o = q_push.size() - b_push;
         chk("push_count", 64'(xfer_o), 64'(exp_d.size()));
         chk("no_pop_on_read", 64'(q_pop.size() - b_pop), 64'd0);
         for (int k = 0; k < exp_d.size() && b_push + k < q_push.size(); k++)
            chk("rdata", 64'(q_push[b_push + k]), 64'(exp_d[k]));
      end
      busy_cnt = n_busy - d_busy;
      first_o  = (acc_o > 0) ? q_acc[b_acc] : 32'h0;
      err_en   = 1'b0;
   endtask

   typedef struct {
      logic        rw;
      logic [31:0] addr;
      logic [7:0]  nb;
      int          err_beat;
      int          stall_beat;
      int          e_acc;
      int          e_xfer;
      logic        e_err;
      logic [31:0] e_first;
      int          e_busy;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int          acc, xfer, bsy, s0, d_done, d_setup, cyc;
      logic [31:0] first, base;
      logic        rw_r, een;
      logic [31:0] addr_r, eaddr;
      logic [7:0]  nb_r;

      //          rw    addr           nb     err stall acc xfer err  first          busy
      tbl[0] = '{1'b0, 32'h0000_0100, 8'd16,  -1, -1,   4,  4,  1'b0, 32'h0000_0100, 14};
      tbl[1] = '{1'b1, 32'h0000_0203, 8'd8,   -1, -1,   2,  2,  1'b0, 32'h0000_0200, 8};
      tbl[2] = '{1'b0, 32'h0000_0100, 8'd16,   1, -1,   2,  1,  1'b1, 32'h0000_0100, 7};
      tbl[3] = '{1'b0, 32'h0000_0100, 8'd16,  -1,  1,   4,  4,  1'b0, 32'h0000_0100, 17};
      tbl[4] = '{1'b0, 32'h0000_0000, 8'd3,   -1, -1,   0,  0,  1'b0, 32'h0000_0000, 2};
      tbl[5] = '{1'b1, 32'hFFFF_FFFC, 8'd8,   -1, -1,   2,  2,  1'b0, 32'hFFFF_FFFC, 8};
      tbl[6] = '{1'b1, 32'h0000_1001, 8'd255, -1, -1,   63, 63, 1'b0, 32'h0000_1000, 191};
      tbl[7] = '{1'b1, 32'h0000_0040, 8'd12,   0, -1,   1,  0,  1'b1, 32'h0000_0040, 4};

      rst = 1'b1; start = 1'b0; rw = 1'b0; start_addr = '0; nbytes = '0;
      wvalid = 1'b0; widx = 0; rready = 1'b1; rand_wv = 1'b0;
      rdy_mode = 0; rdy_rand = 1'b1; err_en = 1'b0; err_addr = '0;
      stall_en = 1'b0; stall_addr = '0;
      repeat (3) step();

      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_psel", 64'(apb.psel), 64'd0);
      chk("rst_penable", 64'(apb.penable), 64'd0);
      chk("rst_paddr", 64'(apb.paddr), 64'd0);
      chk("rst_pwrite", 64'(apb.pwrite), 64'd0);
      chk("rst_pwdata", 64'(apb.pwdata), 64'd0);
      chk("rst_pstrb", 64'(apb.pstrb), 64'd0);
      chk("rst_rdata_valid", 64'(rvalid), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_wdata_ready", 64'(wready), 64'd0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 8; i++) begin
         base       = tbl[i].addr & ~32'h3;
         stall_en   = (tbl[i].stall_beat >= 0);
         stall_addr = base + 32'(4 * tbl[i].stall_beat);
         s0         = n_stall_acc;
         run_xfer(tbl[i].rw, tbl[i].addr, tbl[i].nb, tbl[i].err_beat >= 0,
                  base + 32'(4 * tbl[i].err_beat), acc, xfer, bsy, first);
         chk("tbl_accesses", 64'(acc), 64'(tbl[i].e_acc));
         chk("tbl_transfers", 64'(xfer), 64'(tbl[i].e_xfer));
         chk("tbl_busy_cycles", 64'(bsy), 64'(tbl[i].e_busy));
         chk("tbl_err", 64'(err), 64'(tbl[i].e_err));
         if (tbl[i].e_acc > 0) chk("tbl_first_addr", 64'(first), 64'(tbl[i].e_first));
         if (tbl[i].stall_beat >= 0) chk("stall_access_cycles", 64'(n_stall_acc - s0), 64'd4);
         stall_en = 1'b0;
      end

      // Short transfer with start held high: one done, no bus activity, no retrigger.
      d_done = n_done; d_setup = n_setup;
      rw = 1'b0; start_addr = 32'h0000_0500; nbytes = 8'd3; start = 1'b1;
      repeat (20) step();
      start = 1'b0;
      repeat (2) step();
      chk("hold_done_once", 64'(n_done - d_done), 64'd1);
      chk("hold_no_setup", 64'(n_setup - d_setup), 64'd0);
      chk("hold_busy_end", 64'(busy), 64'd0);

      // Reset while parked in ACCESS: bus and busy drop at once, no done pulse.
      rdy_mode = 2; rdy_rand = 1'b0;
      rw = 1'b0; start_addr = 32'h0000_0100; nbytes = 8'd16; start = 1'b1;
      step();
      start = 1'b0;
      cyc = 0;
      while (!in_acc && cyc < 50) begin
         step();
         cyc++;
      end
      chk("reached_access", 64'(in_acc), 64'd1);
      d_done = n_done;
      rst = 1'b1;
      step();
      chk("rst_mid_psel", 64'(apb.psel), 64'd0);
      chk("rst_mid_penable", 64'(apb.penable), 64'd0);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      rst = 1'b0; rdy_mode = 0;
      repeat (3) step();
      chk("rst_mid_no_done", 64'(n_done - d_done), 64'd0);
      run_xfer(1'b0, 32'h0000_0300, 8'd8, 1'b0, 32'h0, acc, xfer, bsy, first);
      chk("post_rst_accesses", 64'(acc), 64'd2);

      // Write with a toggling write stream.
      rand_wv = 1'b1;
      run_xfer(1'b1, 32'h0000_0203, 8'd8, 1'b0, 32'h0, acc, xfer, bsy, first);
      chk("toggle_pops", 64'(xfer), 64'd2);

      // Randomized descriptors against the reference model.
      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         rw_r   = 1'($urandom_range(1));
         addr_r = $urandom;
         nb_r   = 8'($urandom_range(40));
         een    = (nb_r >= 8'd4) && ($urandom_range(3) == 0);
         eaddr  = een ? (addr_r & ~32'h3) + 32'(4 * $urandom_range(int'(nb_r / 8'd4) - 1)) : 32'h0;
         run_xfer(rw_r, addr_r, nb_r, een, eaddr, acc, xfer, bsy, first);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
